// File: rtl/fetch.sv
// KCP53K cpu2 instruction fetch stage. It owns the PC, runs one Wishbone-style read at a time
// and hands instructions to decode through a one-entry buffer.
module fetch #(
  parameter logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [63:0] iadr_o,
  output logic        icyc_o,
  output logic        istb_o,
  input  logic        iack_i,
  input  logic        ierr_i,
  input  logic [31:0] idat_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic        inst_en_o,
  output logic [63:0] pc_o,
  output logic        fault_o
);

  typedef enum logic [1:0] {StFetch, StDiscard, StFault} state_t;

  state_t      r_state, w_state_d;
  logic [63:0] r_pc, w_pc_d;
  logic [63:0] r_adr, w_adr_d;
  logic [31:0] r_inst, w_inst_d;
  logic [63:0] r_pc_o, w_pc_o_d;
  logic        r_fault, w_fault_d;
  logic        r_inst_en, w_inst_en_d;

  logic w_free, w_xfer, w_stb, w_ack, w_err;

  always_comb begin
    w_xfer = r_inst_en && !stall_i;
    w_free = !r_inst_en || !stall_i;
    w_stb  = 1'b0;
    if (!reset_i) begin
      unique case (r_state)
        StFetch:   w_stb = w_free;
        StDiscard: w_stb = 1'b1;
        default:   w_stb = 1'b0;
      endcase
    end
    w_ack = w_stb && iack_i;
    w_err = w_stb && ierr_i && !iack_i;
  end

  assign istb_o    = w_stb;
  assign icyc_o    = w_stb;
  // In DISCARD the bus still addresses the abandoned fetch while r_pc already holds the target.
  assign iadr_o    = (r_state == StDiscard) ? r_adr : r_pc;
  assign inst_o    = r_inst;
  assign inst_en_o = r_inst_en;
  assign pc_o      = r_pc_o;
  assign fault_o   = r_fault;

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_adr_d     = r_adr;
    w_inst_d    = r_inst;
    w_pc_o_d    = r_pc_o;
    w_fault_d   = r_fault;
    w_inst_en_d = r_inst_en && !w_xfer;
    if (redirect_i) begin
      w_pc_d      = redirect_pc_i & ~64'd3;
      w_inst_en_d = 1'b0;
      if (r_state == StFetch && w_stb && !w_ack && !w_err) begin
        w_state_d = StDiscard;
        w_adr_d   = r_pc;
      end else if (r_state == StDiscard && !w_ack && !w_err) begin
        w_state_d = StDiscard;
      end else begin
        w_state_d = StFetch;
      end
    end else begin
      unique case (r_state)
        StFetch: begin
          if (w_ack) begin
            w_inst_d    = idat_i;
            w_pc_o_d    = r_pc;
            w_fault_d   = 1'b0;
            w_inst_en_d = 1'b1;
            w_pc_d      = r_pc + 64'd4;
          end else if (w_err) begin
            w_inst_d    = 32'd0;
            w_pc_o_d    = r_pc;
            w_fault_d   = 1'b1;
            w_inst_en_d = 1'b1;
            w_state_d   = StFault;
          end
        end
        StDiscard: begin
          if (w_ack || w_err) w_state_d = StFetch;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state   <= StFetch;
      r_pc      <= RESET_PC;
      r_adr     <= RESET_PC;
      r_inst    <= 32'd0;
      r_pc_o    <= 64'd0;
      r_fault   <= 1'b0;
      r_inst_en <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_adr     <= w_adr_d;
      r_inst    <= w_inst_d;
      r_pc_o    <= w_pc_o_d;
      r_fault   <= w_fault_d;
      r_inst_en <= w_inst_en_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: streaming, stall, redirect cases, bus error and mid-cycle reset.
// The slave returns data derived from the address so each instruction is identifiable.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [63:0] iadr_o;
  logic        icyc_o, istb_o;
  logic        iack_i, ierr_i;
  logic [31:0] idat_i;
  logic        stall_i, redirect_i;
  logic [63:0] redirect_pc_i;
  logic [31:0] inst_o;
  logic        inst_en_o, fault_o;
  logic [63:0] pc_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] Rst = 64'hFFFF_FFFF_FFFF_FF00;

  fetch dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .iadr_o       (iadr_o),
    .icyc_o       (icyc_o),
    .istb_o       (istb_o),
    .iack_i       (iack_i),
    .ierr_i       (ierr_i),
    .idat_i       (idat_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .inst_o       (inst_o),
    .inst_en_o    (inst_en_o),
    .pc_o         (pc_o),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  assign idat_i = iadr_o[31:0] ^ 32'h1357_9BDF;

  function automatic logic [63:0] dat(input logic [63:0] a);
    return {32'd0, a[31:0] ^ 32'h1357_9BDF};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1; iack_i = 0; ierr_i = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
    tick(); tick();
    // 0: reset state
    chk("rst_icyc", icyc_o, 0);
    chk("rst_istb", istb_o, 0);
    chk("rst_inst_en", inst_en_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_fault", fault_o, 0);
    chk("rst_iadr", iadr_o, Rst);

    // 1: zero-wait streaming
    reset_i = 0; iack_i = 1; #1;
    chk("t1_istb", istb_o, 1);
    chk("t1_iadr0", iadr_o, Rst);
    tick();
    chk("t1_en0", inst_en_o, 1);
    chk("t1_pc0", pc_o, Rst);
    chk("t1_inst0", inst_o, dat(Rst));
    chk("t1_iadr1", iadr_o, Rst + 4);
    tick();
    chk("t1_en1", inst_en_o, 1);
    chk("t1_pc1", pc_o, Rst + 4);
    chk("t1_iadr2", iadr_o, Rst + 8);

    // 2: stall with buffer full
    stall_i = 1; #1;
    chk("t2_istb_lo", istb_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold_en", inst_en_o, 1);
      chk("t2_hold_pc", pc_o, Rst + 4);
      chk("t2_hold_inst", inst_o, dat(Rst + 4));
      chk("t2_hold_istb", istb_o, 0);
      chk("t2_hold_iadr", iadr_o, Rst + 8);
    end
    stall_i = 0; #1;
    chk("t2_resume_istb", istb_o, 1);
    chk("t2_resume_iadr", iadr_o, Rst + 8);
    tick();
    chk("t2_next_pc", pc_o, Rst + 8);
    chk("t2_next_iadr", iadr_o, Rst + 12);

    // 3: redirect during a wait-stated fetch of FF04
    reset_i = 1; tick();
    reset_i = 0; tick();
    iack_i = 0; #1;
    chk("t3_istb", istb_o, 1);
    chk("t3_iadr", iadr_o, Rst + 4);
    tick();
    redirect_i = 1; redirect_pc_i = 64'h1000;
    tick();
    redirect_i = 0; #1;
    chk("t3_disc_istb", istb_o, 1);
    chk("t3_disc_iadr", iadr_o, Rst + 4);
    chk("t3_disc_en", inst_en_o, 0);
    iack_i = 1;
    tick();
    chk("t3_drop_en", inst_en_o, 0);
    chk("t3_new_iadr", iadr_o, 64'h1000);
    chk("t3_new_istb", istb_o, 1);
    tick();
    chk("t3_en", inst_en_o, 1);
    chk("t3_pc", pc_o, 64'h1000);

    // 4: redirect in the same clock as ack
    redirect_i = 1; redirect_pc_i = 64'h2003;
    tick();
    redirect_i = 0; #1;
    chk("t4_flush_en", inst_en_o, 0);
    chk("t4_iadr", iadr_o, 64'h2000);
    tick();
    chk("t4_en", inst_en_o, 1);
    chk("t4_pc", pc_o, 64'h2000);
    chk("t4_inst", inst_o, dat(64'h2000));

    // 5: bus error on FF08
    reset_i = 1; tick();
    reset_i = 0; tick(); tick();
    iack_i = 0; ierr_i = 1;
    tick();
    ierr_i = 0; iack_i = 1; #1;
    chk("t5_en", inst_en_o, 1);
    chk("t5_inst", inst_o, 0);
    chk("t5_fault", fault_o, 1);
    chk("t5_pc", pc_o, Rst + 8);
    chk("t5_icyc", icyc_o, 0);
    tick();
    chk("t5_icyc_wait", icyc_o, 0);
    chk("t5_en_drained", inst_en_o, 0);
    redirect_i = 1; redirect_pc_i = 64'h3000;
    tick();
    redirect_i = 0; #1;
    chk("t5_resume_icyc", icyc_o, 1);
    chk("t5_resume_iadr", iadr_o, 64'h3000);
    tick();
    chk("t5_new_pc", pc_o, 64'h3000);
    chk("t5_new_fault", fault_o, 0);
    chk("t5_new_en", inst_en_o, 1);

    // 6: reset while a fetch is waiting
    iack_i = 0; tick();
    chk("t6_waiting", icyc_o, 1);
    reset_i = 1; tick();
    chk("t6_icyc", icyc_o, 0);
    chk("t6_en", inst_en_o, 0);
    reset_i = 0; iack_i = 1; #1;
    chk("t6_iadr", iadr_o, Rst);
    tick();
    chk("t6_pc", pc_o, Rst);
    chk("t6_en_after", inst_en_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
